// File: rtl/obstacle_spawn_ctrl.sv
// Obstacle spawn scheduler: waits a random number of frame ticks, picks a lane
// and kind, then offers one spawn request at a time over valid/ready.
module obstacle_spawn_ctrl #(
  parameter int RW      = 3,
  parameter int GAP_MIN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic [RW-1:0]    rnd,
  input  logic [1:0]       level,
  input  logic             spawn_ready,
  output logic             spawn_valid,
  output logic [1:0]       spawn_lane,
  output logic             spawn_kind,
  output logic             busy,
  output logic [CNT_W-1:0] spawn_count
);

  // Wide enough for GAP_MIN + 2^RW - 1 without overflow.
  localparam int GW = RW + $clog2(GAP_MIN + 1) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, SPAWN} state_t;

  state_t           state_reg, state_next;
  logic [GW-1:0]    gap_cnt_reg;
  logic [GW-1:0]    gap_load;
  logic [1:0]       last_lane_reg, rep_cnt_reg;
  logic [1:0]       lane_raw, lane_sel;
  logic [1:0]       spawn_lane_reg;
  logic             spawn_kind_reg, spawn_valid_reg, busy_reg;
  logic [CNT_W-1:0] spawn_count_reg;
  logic             latch, handshake;

  function automatic logic [1:0] next_lane(input logic [1:0] l);
    return (l == 2'd2) ? 2'd0 : l + 2'd1;
  endfunction

  assign gap_load = GW'(GAP_MIN) + GW'(rnd >> level);

  // Lane 3 is not a real lane; remap it, then break a third repeat in a row.
  assign lane_raw = (rnd[1:0] == 2'd3) ? next_lane(last_lane_reg) : rnd[1:0];
  assign lane_sel = (lane_raw == last_lane_reg && rep_cnt_reg == 2'd1)
                    ? next_lane(lane_raw) : lane_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    handshake  = 1'b0;
    case (state_reg)
      IDLE:  if (enable) state_next = LOAD;
      LOAD:  state_next = enable ? WAIT : IDLE;
      WAIT: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (tick && gap_cnt_reg == GW'(1)) begin
          state_next = SPAWN;
          latch      = 1'b1;
        end
      end
      SPAWN: begin
        // enable is only honoured once the pending request has been accepted
        if (spawn_ready) begin
          handshake  = 1'b1;
          state_next = enable ? LOAD : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt_reg     <= '0;
      last_lane_reg   <= 2'd0;
      rep_cnt_reg     <= 2'd0;
      spawn_lane_reg  <= 2'd0;
      spawn_kind_reg  <= 1'b0;
      spawn_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
      spawn_count_reg <= '0;
    end else begin
      spawn_valid_reg <= (state_next == SPAWN);
      busy_reg        <= (state_next != IDLE);
      if (state_reg == LOAD)
        gap_cnt_reg <= gap_load;
      else if (state_reg == WAIT && enable && tick)
        gap_cnt_reg <= gap_cnt_reg - GW'(1);
      if (latch) begin
        spawn_lane_reg <= lane_sel;
        spawn_kind_reg <= rnd[2];
      end
      if (handshake) begin
        spawn_count_reg <= spawn_count_reg + CNT_W'(1);
        last_lane_reg   <= spawn_lane_reg;
        if (spawn_lane_reg == last_lane_reg)
          rep_cnt_reg <= (rep_cnt_reg == 2'd2) ? 2'd2 : rep_cnt_reg + 2'd1;
        else
          rep_cnt_reg <= 2'd0;
      end
    end
  end

  assign spawn_valid = spawn_valid_reg;
  assign spawn_lane  = spawn_lane_reg;
  assign spawn_kind  = spawn_kind_reg;
  assign busy        = busy_reg;
  assign spawn_count = spawn_count_reg;

endmodule

// File: tb/tb_obstacle_spawn_ctrl.sv
// Directed testbench for obstacle_spawn_ctrl: gap timing, lane selection,
// backpressure, enable handling, asynchronous reset and counter wrap.
module tb_obstacle_spawn_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       tick;
  logic [2:0] rnd;
  logic [1:0] level;
  logic       spawn_ready;
  logic       spawn_valid;
  logic [1:0] spawn_lane;
  logic       spawn_kind;
  logic       busy;
  logic [7:0] spawn_count;

  int n_checks = 0;
  int n_fail   = 0;

  obstacle_spawn_ctrl #(.RW(3), .GAP_MIN(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick), .rnd(rnd),
    .level(level), .spawn_ready(spawn_ready), .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane), .spawn_kind(spawn_kind), .busy(busy),
    .spawn_count(spawn_count)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b0; enable = 1'b0; tick = 1'b0; spawn_ready = 1'b0;
    rnd = 3'd0; level = 2'd0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // From IDLE: raise enable, wait for WAIT, then hold tick high and count
  // ticks until spawn_valid appears (64 means it never did).
  task automatic run_gap(input logic [1:0] lv, input logic [2:0] r, output int n);
    level = lv; rnd = r; tick = 1'b0; enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b1; n = 0;
    while (n < 64) begin
      @(negedge clk);
      n++;
      if (spawn_valid) break;
    end
    tick = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    apply_reset();
    n_checks++;
    if ({spawn_valid, spawn_lane, spawn_kind, busy, spawn_count} !== 13'd0) begin
      n_fail++; $display("FAIL reset_idle: got v=%0b l=%0d k=%0b b=%0b c=%0d expected all 0",
                         spawn_valid, spawn_lane, spawn_kind, busy, spawn_count);
    end
    run_gap(2'd3, 3'd5, n);
    n_checks++;
    if (spawn_valid !== 1'b1 || spawn_lane !== 2'd1 || spawn_kind !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_spawn: got v=%0b l=%0d k=%0b expected v=1 l=1 k=1",
                         spawn_valid, spawn_lane, spawn_kind);
    end
    spawn_ready = 1'b1; enable = 1'b0;
    @(negedge clk);
    spawn_ready = 1'b0;
    n_checks++;
    if (spawn_count !== 8'd1) begin
      n_fail++; $display("FAIL reset_count_before: got %0d expected 1", spawn_count);
    end
    run_gap(2'd3, 3'd5, n);
    n_checks++;
    if (spawn_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_second_spawn: got valid=%0b expected 1", spawn_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({spawn_valid, spawn_lane, spawn_kind, busy, spawn_count} !== 13'd0) begin
      n_fail++; $display("FAIL reset_async: got v=%0b l=%0d k=%0b b=%0b c=%0d expected all 0",
                         spawn_valid, spawn_lane, spawn_kind, busy, spawn_count);
    end
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || spawn_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_after_release: got busy=%0b valid=%0b expected 0 0", busy, spawn_valid);
    end
    $display("test_reset: async reset dropped pending request");
  endtask

  task automatic test_basic_gap();
    apply_reset();
    level = 2'd0; rnd = 3'd3; spawn_ready = 1'b1; enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_load: got %0b expected 1", busy);
    end
    @(negedge clk);
    for (int i = 1; i <= 7; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      n_checks++;
      if (spawn_valid !== (i == 7)) begin
        n_fail++; $display("FAIL basic_valid_tick%0d: got %0b expected %0b", i, spawn_valid, (i == 7));
      end
      if (i < 7) @(negedge clk);
    end
    n_checks++;
    if (spawn_lane !== 2'd1 || spawn_kind !== 1'b0 || spawn_count !== 8'd0) begin
      n_fail++; $display("FAIL basic_lane_kind: got l=%0d k=%0b c=%0d expected l=1 k=0 c=0",
                         spawn_lane, spawn_kind, spawn_count);
    end
    @(negedge clk);
    n_checks++;
    if (spawn_valid !== 1'b0 || spawn_count !== 8'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_handshake: got v=%0b c=%0d b=%0b expected v=0 c=1 b=1",
                         spawn_valid, spawn_count, busy);
    end
    enable = 1'b0; spawn_ready = 1'b0;
    @(negedge clk);
    $display("test_basic_gap: lane=%0d kind=%0b count=%0d", spawn_lane, spawn_kind, spawn_count);
  endtask

  task automatic test_level_scaling();
    int n;
    logic [1:0] lv_tab [3] = '{2'd2, 2'd3, 2'd0};
    logic [2:0] rn_tab [3] = '{3'd7, 3'd7, 3'd7};
    int         g_tab  [3] = '{5, 4, 11};
    for (int t = 0; t < 3; t++) begin
      apply_reset();
      run_gap(lv_tab[t], rn_tab[t], n);
      n_checks++;
      if (n !== g_tab[t]) begin
        n_fail++; $display("FAIL level_gap%0d: got %0d ticks expected %0d", t, n, g_tab[t]);
      end
      $display("test_level_scaling: level=%0d rnd=%0d gap=%0d", lv_tab[t], rn_tab[t], n);
    end
  endtask

  task automatic test_backpressure();
    int n;
    apply_reset();
    run_gap(2'd3, 3'd6, n);
    n_checks++;
    if (n !== 4) begin
      n_fail++; $display("FAIL bp_gap: got %0d expected 4", n);
    end
    rnd = 3'd1;
    for (int i = 0; i < 10; i++) begin
      tick = i[0];
      @(negedge clk);
      n_checks++;
      if (spawn_valid !== 1'b1 || spawn_lane !== 2'd2 || spawn_kind !== 1'b1 || spawn_count !== 8'd0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%0b l=%0d k=%0b c=%0d expected v=1 l=2 k=1 c=0",
                           i, spawn_valid, spawn_lane, spawn_kind, spawn_count);
      end
    end
    tick = 1'b0; spawn_ready = 1'b1;
    @(negedge clk);
    spawn_ready = 1'b0;
    n_checks++;
    if (spawn_valid !== 1'b0 || spawn_count !== 8'd1) begin
      n_fail++; $display("FAIL bp_release: got v=%0b c=%0d expected v=0 c=1", spawn_valid, spawn_count);
    end
    @(negedge clk);
    n_checks++;
    if (spawn_count !== 8'd1) begin
      n_fail++; $display("FAIL bp_single_count: got %0d expected 1", spawn_count);
    end
    enable = 1'b0;
    @(negedge clk);
    $display("test_backpressure: count=%0d", spawn_count);
  endtask

  task automatic test_repeat_limit();
    int n;
    logic [2:0] rn_tab [5] = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd0};
    logic [1:0] ln_tab [5] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
    apply_reset();
    for (int s = 0; s < 5; s++) begin
      run_gap(2'd3, rn_tab[s], n);
      n_checks++;
      if (spawn_valid !== 1'b1 || spawn_lane !== ln_tab[s]) begin
        n_fail++; $display("FAIL repeat_lane%0d: got v=%0b lane=%0d expected v=1 lane=%0d",
                           s, spawn_valid, spawn_lane, ln_tab[s]);
      end
      $display("test_repeat_limit: spawn %0d raw=%0d lane=%0d", s, rn_tab[s][1:0], spawn_lane);
      enable = 1'b0; spawn_ready = 1'b1;
      @(negedge clk);
      spawn_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    apply_reset();
    level = 2'd0; rnd = 3'd3; enable = 1'b1;
    @(negedge clk); @(negedge clk);
    tick = 1'b1;
    @(negedge clk); @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_wait_busy: got %0b expected 0", busy);
    end
    for (int i = 0; i < 8; i++) @(negedge clk);
    tick = 1'b0;
    n_checks++;
    if (spawn_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_wait_idle: got v=%0b b=%0b expected 0 0", spawn_valid, busy);
    end
    run_gap(2'd3, 3'd0, n);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (spawn_valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++; $display("FAIL drop_spawn_hold%0d: got v=%0b b=%0b expected 1 1", i, spawn_valid, busy);
      end
    end
    spawn_ready = 1'b1;
    @(negedge clk);
    spawn_ready = 1'b0;
    n_checks++;
    if (spawn_valid !== 1'b0 || busy !== 1'b0 || spawn_count !== 8'd1) begin
      n_fail++; $display("FAIL drop_spawn_done: got v=%0b b=%0b c=%0d expected v=0 b=0 c=1",
                         spawn_valid, busy, spawn_count);
    end
    $display("test_enable_drop: count=%0d", spawn_count);
  endtask

  task automatic test_count_wrap();
    int hs  = 0;
    int cyc = 0;
    apply_reset();
    level = 2'd3; rnd = 3'd0; spawn_ready = 1'b1; tick = 1'b1; enable = 1'b1;
    while (hs < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (spawn_valid) begin
        hs++;
        if (hs == 256) begin
          enable = 1'b0;
          n_checks++;
          if (spawn_count !== 8'd255) begin
            n_fail++; $display("FAIL wrap_pre: got %0d expected 255", spawn_count);
          end
        end
      end
    end
    n_checks++;
    if (hs != 256) begin
      n_fail++; $display("FAIL wrap_timeout: got %0d spawns expected 256", hs);
    end
    @(negedge clk);
    tick = 1'b0; spawn_ready = 1'b0;
    n_checks++;
    if (spawn_count !== 8'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL wrap_zero: got c=%0d b=%0b expected c=0 b=0", spawn_count, busy);
    end
    $display("test_count_wrap: %0d spawns, count=%0d", hs, spawn_count);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; tick = 1'b0; spawn_ready = 1'b0;
    rnd = 3'd0; level = 2'd0;
    test_reset();
    test_basic_gap();
    test_level_scaling();
    test_backpressure();
    test_repeat_limit();
    test_enable_drop();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
